// File: rtl/mips_mem_responder_if.sv
// Fetch and data-access signal bundle between the MIPS core (master) and the
// memory responder (slave).
interface mips_mem_responder_if;
   logic [31:0] PCF;
   logic [31:0] ImmRD;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic        MemWriteM;
   logic        MemReadM;
   logic [31:0] DmmRD;
   logic        MemStall;
   logic        misalign_err;

   modport master (
      output PCF, ALUOutM, WriteDataM, MemWriteM, MemReadM,
      input  ImmRD, DmmRD, MemStall, misalign_err
   );

   modport slave (
      input  PCF, ALUOutM, WriteDataM, MemWriteM, MemReadM,
      output ImmRD, DmmRD, MemStall, misalign_err
   );
endinterface

// File: rtl/mips_mem_responder.sv
// Unified word RAM serving the MIPS IF-stage fetch (combinational) and MEM-stage loads
// (WAIT_STATES extra cycles, exposed via MemStall). MIPS_MEM_MISALIGN_CHECK_EN traps misaligned accesses.
module mips_mem_responder #(
   parameter int DEPTH       = 1024,
   parameter int AW          = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   mips_mem_responder_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   logic [31:0]   mem [DEPTH];
   state_t        state;
   logic [3:0]    cnt;
   logic [AW-1:0] lat_idx;
   logic [31:0]   dmm_rd;

   logic [AW-1:0] fetch_idx;
   logic [AW-1:0] data_idx;
   logic          data_ok;
   logic          store_en;
   logic          load_req;
   logic          unused_addr_bits;

   // Upper address bits wrap modulo DEPTH words and are deliberately ignored.
   assign fetch_idx = bus.PCF[AW+1:2];
   assign data_idx  = bus.ALUOutM[AW+1:2];
   assign unused_addr_bits = ^{bus.PCF[31:AW+2], bus.PCF[1:0],
                               bus.ALUOutM[31:AW+2], bus.ALUOutM[1:0]};

`ifdef MIPS_MEM_MISALIGN_CHECK_EN
   logic data_mis;
   logic fetch_mis;
   logic err;

   assign data_mis  = (bus.MemWriteM | bus.MemReadM) & (bus.ALUOutM[1:0] != 2'b00);
   assign fetch_mis = (bus.PCF[1:0] != 2'b00);
   assign data_ok   = !data_mis;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (data_mis | fetch_mis) begin
         err <= 1'b1;
      end
   end

   assign bus.misalign_err = err;
`else
   assign data_ok          = 1'b1;
   assign bus.misalign_err = 1'b0;
`endif

   assign store_en = bus.MemWriteM & data_ok;
   assign load_req = bus.MemReadM & !bus.MemWriteM & data_ok;

   // RAM contents survive reset, so the array sits outside the reset domain.
   always_ff @(posedge clk) begin
      if (store_en) begin
         mem[data_idx] <= bus.WriteDataM;
      end
   end

   assign bus.ImmRD = mem[fetch_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         lat_idx <= '0;
         dmm_rd  <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (load_req) begin
                  lat_idx <= data_idx;
                  cnt     <= WS;
                  if (WS == 4'd0) begin
                     state  <= S_DONE;
                     dmm_rd <= mem[data_idx];
                  end else begin
                     state  <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state  <= S_DONE;
                  dmm_rd <= mem[lat_idx];
               end
            end
            // The request is still on the bus here; it has been served and must not retrigger.
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.DmmRD    = dmm_rd;
   assign bus.MemStall = reset & (((state == S_IDLE) & load_req) | (state == S_WAIT));
endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder: one DUT with 2 wait states, one with none;
// stimulus queues expected loads/fetches, a negedge monitor pops and compares.
module tb_mips_mem_responder;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] pcf = 32'd0;
   logic [31:0] alu = 32'd0;
   logic [31:0] wd  = 32'd0;
   logic        mw  = 1'b0;
   logic        mr  = 1'b0;
   logic        sel = 1'b0;
   logic        fetch_strobe = 1'b0;

   mips_mem_responder_if bus_a();
   mips_mem_responder_if bus_b();

   assign bus_a.PCF        = pcf;
   assign bus_a.ALUOutM    = alu;
   assign bus_a.WriteDataM = wd;
   assign bus_a.MemWriteM  = mw & !sel;
   assign bus_a.MemReadM   = mr & !sel;
   assign bus_b.PCF        = pcf;
   assign bus_b.ALUOutM    = alu;
   assign bus_b.WriteDataM = wd;
   assign bus_b.MemWriteM  = mw & sel;
   assign bus_b.MemReadM   = mr & sel;

   mips_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_STATES(2)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a));
   mips_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_STATES(0)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b));

   logic [31:0] m_imm, m_dmm;
   logic        m_stall, m_err;
   assign m_imm   = sel ? bus_b.ImmRD        : bus_a.ImmRD;
   assign m_dmm   = sel ? bus_b.DmmRD        : bus_a.DmmRD;
   assign m_stall = sel ? bus_b.MemStall     : bus_a.MemStall;
   assign m_err   = sel ? bus_b.misalign_err : bus_a.misalign_err;

   typedef struct {
      logic [31:0] data;
      int          stalls;
   } exp_t;

   exp_t        load_q[$];
   logic [31:0] fetch_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int n_load = 0;
   int stall_run = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("check %s: %h", name, act);
      end
   endtask

   // Monitor: pops an expectation whenever a load completes or a fetch is strobed.
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] fe;
      if (!reset) begin
         stall_run = 0;
      end else begin
         if (mw) begin
            n_cmp++;
            if (m_stall !== 1'b0) begin
               n_bad++;
               $display("FAIL store_stall: got %b expected 0", m_stall);
            end
         end else if (mr) begin
            if (m_stall === 1'b1) begin
               stall_run++;
            end else begin
               n_cmp++;
               if (load_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL unexpected_load: got data %h with nothing expected", m_dmm);
               end else begin
                  e = load_q.pop_front();
                  n_load++;
                  $display("load %0d dut%s addr=%h data=%h stalls=%0d", n_load, sel ? "B" : "A",
                           alu, m_dmm, stall_run);
                  if (m_dmm !== e.data) begin
                     n_bad++;
                     $display("FAIL load_data: got %h expected %h", m_dmm, e.data);
                  end
                  n_cmp++;
                  if (stall_run != e.stalls) begin
                     n_bad++;
                     $display("FAIL load_stalls: got %0d expected %0d", stall_run, e.stalls);
                  end
               end
               stall_run = 0;
            end
         end else begin
            n_cmp++;
            if (m_stall !== 1'b0) begin
               n_bad++;
               $display("FAIL idle_stall: got %b expected 0", m_stall);
            end
         end
         if (fetch_strobe) begin
            n_cmp++;
            if (fetch_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_fetch: got %h with nothing expected", m_imm);
            end else begin
               fe = fetch_q.pop_front();
               $display("fetch pc=%h instr=%h", pcf, m_imm);
               if (m_imm !== fe) begin
                  n_bad++;
                  $display("FAIL fetch_data: got %h expected %h", m_imm, fe);
               end
            end
         end
      end
   end

   task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
      alu = addr; wd = data; mw = 1'b1; mr = 1'b0;
      @(posedge clk); #1;
      mw = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [31:0] exp, input bit hold);
      exp_t e;
      int n;
      e.data = exp;
      e.stalls = sel ? 1 : 3;
      load_q.push_back(e);
      alu = addr; mr = 1'b1; mw = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_stall === 1'b1 && n < 40);
      if (m_stall === 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL load_timeout: stall still %b after %0d cycles, expected release", m_stall, n);
      end
      @(posedge clk); #1;
      if (!hold) mr = 1'b0;
   endtask

   task automatic check_fetch(input logic [31:0] pc, input logic [31:0] exp);
      pcf = pc;
      fetch_q.push_back(exp);
      fetch_strobe = 1'b1;
      @(posedge clk); #1;
      fetch_strobe = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_stall_a", {31'd0, bus_a.MemStall}, 32'd0);
      check("reset_dmm_a", bus_a.DmmRD, 32'd0);
      check("reset_err_a", {31'd0, bus_a.misalign_err}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Program image and fetch, including same-cycle store invisibility
      do_store(32'h0, 32'h20080005);
      do_store(32'h4, 32'h2009000A);
      do_store(32'h8, 32'h01095020);
      check_fetch(32'h0, 32'h20080005);
      check_fetch(32'h4, 32'h2009000A);
      check_fetch(32'h8, 32'h01095020);
      do_store(32'hC, 32'h11111111);
      pcf = 32'hC; alu = 32'hC; wd = 32'h22222222; mw = 1'b1;
      fetch_q.push_back(32'h11111111);
      fetch_strobe = 1'b1;
      @(posedge clk); #1;
      mw = 1'b0; fetch_strobe = 1'b0;
      check_fetch(32'hC, 32'h22222222);

      // Store then next-cycle load, 2 wait states
      do_store(32'h40, 32'hDEADBEEF);
      do_load(32'h40, 32'hDEADBEEF, 1'b0);
      @(posedge clk); #1;
      check("dmm_hold", m_dmm, 32'hDEADBEEF);

      // Address wrap modulo 1024 words
      do_store(32'h1000, 32'h12345678);
      do_load(32'h0, 32'h12345678, 1'b0);

      // Simultaneous store and load: store wins
      alu = 32'h80; wd = 32'hA5A5A5A5; mw = 1'b1; mr = 1'b1;
      @(posedge clk); #1;
      mw = 1'b0; mr = 1'b0;
      check("both_dmm_unchanged", m_dmm, 32'h12345678);
      do_load(32'h80, 32'hA5A5A5A5, 1'b0);

      // Back-to-back loads with request held across DONE
      do_load(32'h40, 32'hDEADBEEF, 1'b1);
      do_load(32'h80, 32'hA5A5A5A5, 1'b0);

      // Reset in the middle of a load
      alu = 32'h40; mr = 1'b1;
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check("midload_reset_stall", {31'd0, bus_a.MemStall}, 32'd0);
      check("midload_reset_dmm_a", bus_a.DmmRD, 32'd0);
      check("midload_reset_dmm_b", bus_b.DmmRD, 32'd0);
      mr = 1'b0;
      @(posedge clk); #3;
      reset = 1'b1;
      @(posedge clk); #1;
      do_load(32'h40, 32'hDEADBEEF, 1'b0);

      // Misaligned store
      do_store(32'h42, 32'hCAFEF00D);
`ifdef MIPS_MEM_MISALIGN_CHECK_EN
      check("misalign_err", {31'd0, m_err}, 32'd1);
      do_load(32'h40, 32'hDEADBEEF, 1'b0);
      check("misalign_err_sticky", {31'd0, m_err}, 32'd1);
`else
      check("misalign_err", {31'd0, m_err}, 32'd0);
      do_load(32'h40, 32'hCAFEF00D, 1'b0);
`endif

      // Zero wait-state instance
      sel = 1'b1;
      @(posedge clk); #1;
      do_store(32'h40, 32'h0BADC0DE);
      do_load(32'h40, 32'h0BADC0DE, 1'b0);
      do_store(32'h84, 32'h600DF00D);
      do_load(32'h40, 32'h0BADC0DE, 1'b1);
      do_load(32'h84, 32'h600DF00D, 1'b0);
      @(posedge clk); #1;
      check("dmm_hold_b", m_dmm, 32'h600DF00D);

      check("load_queue_drained", 32'(load_q.size()), 32'd0);
      check("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
